// File: rtl/banked_register_file_if.sv
// banked_register_file_if
//   Bus between decode/issue + writeback (master) and the banked register
//   file (slave).
//   Read side : read_rn/rm/rs addresses -> rn/rm/rs_out data, rn/rm/rs_busy
//   Write side: port A (rd_we/write_rd/rd_in), port B (rb_we/write_rb/rb_in)
//   Issue     : issue_we/issue_rd reserve a destination register
//   Direct    : pc_we/pc_in, cpsr_we/cpsr_in; raw pc_out/cpsr_out
interface banked_register_file_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] read_rn, read_rm, read_rs;
  logic [WORD_SIZE-1:0]  rn_out, rm_out, rs_out;
  logic                  rn_busy, rm_busy, rs_busy;

  logic                  rd_we;
  logic [ADDR_WIDTH-1:0] write_rd;
  logic [WORD_SIZE-1:0]  rd_in;
  logic                  rb_we;
  logic [ADDR_WIDTH-1:0] write_rb;
  logic [WORD_SIZE-1:0]  rb_in;

  logic                  issue_we;
  logic [ADDR_WIDTH-1:0] issue_rd;

  logic [WORD_SIZE-1:0]  pc_in, cpsr_in;
  logic                  pc_we, cpsr_we;
  logic [WORD_SIZE-1:0]  pc_out, cpsr_out;

  modport master (
    output read_rn, read_rm, read_rs,
    output rd_we, write_rd, rd_in, rb_we, write_rb, rb_in,
    output issue_we, issue_rd, pc_in, cpsr_in, pc_we, cpsr_we,
    input  rn_out, rm_out, rs_out, rn_busy, rm_busy, rs_busy,
    input  pc_out, cpsr_out
  );

  modport slave (
    input  read_rn, read_rm, read_rs,
    input  rd_we, write_rd, rd_in, rb_we, write_rb, rb_in,
    input  issue_we, issue_rd, pc_in, cpsr_in, pc_we, cpsr_we,
    output rn_out, rm_out, rs_out, rn_busy, rm_busy, rs_busy,
    output pc_out, cpsr_out
  );
endinterface

// File: rtl/banked_register_file.sv
// banked_register_file
//   Register file for the pipelined ARM datapath: r0..r12 shared, r13/r14
//   banked by the low CPSR bits, r15 is the PC, plus a CPSR and a
//   per-register scoreboard of in-flight writes.
//   Ports:
//     clk   - clock, all state changes on the rising edge
//     reset - synchronous, active-high; clears every register and reservation
//     bus   - banked_register_file_if slave: three combinational read ports
//             with write-through bypass, two write ports (A beats B), issue
//             reservation, direct PC/CPSR writes, raw PC/CPSR outputs
module banked_register_file #(
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int NUM_BANKS      = 4,
  parameter int PC_READ_OFFSET = 8
) (
  input logic                   clk,
  input logic                   reset,
  banked_register_file_if.slave bus
);
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int NUM_GPR   = NUM_REGS - 3;
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [WORD_SIZE-1:0]  word_t;

  localparam addr_t R13    = addr_t'(NUM_REGS - 3);
  localparam addr_t R14    = addr_t'(NUM_REGS - 2);
  localparam addr_t R15    = addr_t'(NUM_REGS - 1);
  localparam word_t PC_OFS = word_t'(PC_READ_OFFSET);

  word_t               gpr_q [NUM_GPR];
  word_t               r13_q [NUM_BANKS];
  word_t               r14_q [NUM_BANKS];
  word_t               pc_q;
  word_t               cpsr_q;
  logic [NUM_REGS-1:0] sb_q;

  // Local copies of the bus inputs keep the read function free of
  // hierarchical references.
  logic  rd_we, rb_we, issue_we, pc_we, cpsr_we;
  addr_t write_rd, write_rb, issue_rd;
  word_t rd_in, rb_in, pc_in, cpsr_in;

  assign rd_we    = bus.rd_we;
  assign rb_we    = bus.rb_we;
  assign issue_we = bus.issue_we;
  assign pc_we    = bus.pc_we;
  assign cpsr_we  = bus.cpsr_we;
  assign write_rd = bus.write_rd;
  assign write_rb = bus.write_rb;
  assign issue_rd = bus.issue_rd;
  assign rd_in    = bus.rd_in;
  assign rb_in    = bus.rb_in;
  assign pc_in    = bus.pc_in;
  assign cpsr_in  = bus.cpsr_in;

  // Bank comes from the registered CPSR only, so a CPSR write changes the
  // r13/r14 view from the following cycle. A single bank always selects 0.
  logic [BANK_BITS-1:0] bank;
  assign bank = (NUM_BANKS == 1) ? '0 : cpsr_q[BANK_BITS-1:0];

  // Same address implies same bank, because reads and writes share `bank`.
  function automatic word_t read_port(addr_t a);
    word_t v;
    if (rd_we && write_rd == a)      v = rd_in;
    else if (rb_we && write_rb == a) v = rb_in;
    else if (a == R15)               v = pc_q;
    else if (a == R14)               v = r14_q[bank];
    else if (a == R13)               v = r13_q[bank];
    else                             v = gpr_q[a];
    // r15 reads see the pipeline-visible PC, bypassed or not.
    if (a == R15) v = v + PC_OFS;
    return v;
  endfunction

  assign bus.rn_out   = read_port(bus.read_rn);
  assign bus.rm_out   = read_port(bus.read_rm);
  assign bus.rs_out   = read_port(bus.read_rs);
  assign bus.rn_busy  = sb_q[bus.read_rn];
  assign bus.rm_busy  = sb_q[bus.read_rm];
  assign bus.rs_busy  = sb_q[bus.read_rs];
  assign bus.pc_out   = pc_q;
  assign bus.cpsr_out = cpsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this storage is plain flops, not an SRAM macro, and reset must
      // leave every register architecturally zero, so the arrays are cleared
      // in full here.
      for (int i = 0; i < NUM_GPR; i++)   gpr_q[i] <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r13_q[b] <= '0;
        r14_q[b] <= '0;
      end
      pc_q   <= '0;
      cpsr_q <= '0;
      sb_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, and when several of them below hit
      // the same register the last one in program order wins; the ordering
      // (pc_we, then port B, then port A; clears before issue) is how the
      // priority rules are expressed.
      if (pc_we)   pc_q   <= pc_in;
      if (cpsr_we) cpsr_q <= cpsr_in;

      if (rb_we) begin
        if (write_rb == R15)      pc_q         <= rb_in;
        else if (write_rb == R14) r14_q[bank]  <= rb_in;
        else if (write_rb == R13) r13_q[bank]  <= rb_in;
        else                      gpr_q[write_rb] <= rb_in;
      end

      if (rd_we) begin
        if (write_rd == R15)      pc_q         <= rd_in;
        else if (write_rd == R14) r14_q[bank]  <= rd_in;
        else if (write_rd == R13) r13_q[bank]  <= rd_in;
        else                      gpr_q[write_rd] <= rd_in;
      end

      // Writeback releases a reservation; a same-cycle new issue re-arms it.
      if (rb_we)    sb_q[write_rb] <= 1'b0;
      if (rd_we)    sb_q[write_rd] <= 1'b0;
      if (issue_we) sb_q[issue_rd] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_banked_register_file.sv
// tb_banked_register_file
//   Scoreboard bench for banked_register_file. A driver issues one stimulus
//   per cycle, computes the expected read-port / busy / PC / CPSR outputs
//   from a behavioural model of the register file and queues them; a monitor
//   on the falling edge pops and compares against the DUT.
module tb_banked_register_file;
  localparam int WS = 32;
  localparam int AW = 4;

  typedef struct {
    logic [3:0]  rn, rm, rs;
    logic        rd_we;
    logic [3:0]  wrd;
    logic [31:0] rd_in;
    logic        rb_we;
    logic [3:0]  wrb;
    logic [31:0] rb_in;
    logic        issue_we;
    logic [3:0]  issue_rd;
    logic        pc_we;
    logic [31:0] pc_in;
    logic        cpsr_we;
    logic [31:0] cpsr_in;
  } stim_t;

  typedef struct {
    string       tag;
    logic [31:0] rn, rm, rs, pc, cpsr;
    logic        rn_b, rm_b, rs_b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  banked_register_file_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

  banked_register_file #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_BANKS(4), .PC_READ_OFFSET(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Architectural view: 13 shared registers, r13/r14 per bank (4 banks
  // selected by cpsr mod 4), PC, CPSR, and a set of reserved registers.
  logic [31:0] m_shared [13];
  logic [31:0] m_sp [4];
  logic [31:0] m_lr [4];
  logic [31:0] m_pc, m_cpsr;
  bit          m_reserved [16];

  function automatic logic [31:0] m_value(int a);
    int bk = int'(m_cpsr % 4);
    if (a == 15) return m_pc;
    if (a == 14) return m_lr[bk];
    if (a == 13) return m_sp[bk];
    return m_shared[a];
  endfunction

  function automatic logic [31:0] m_read(stim_t s, logic [3:0] a);
    logic [31:0] v;
    if (s.rd_we && s.wrd == a)      v = s.rd_in;
    else if (s.rb_we && s.wrb == a) v = s.rb_in;
    else                            v = m_value(int'(a));
    if (a == 4'd15) v = v + 32'd8;
    return v;
  endfunction

  task automatic m_store(int a, logic [31:0] d, int bk);
    if (a == 15)      m_pc = d;
    else if (a == 14) m_lr[bk] = d;
    else if (a == 13) m_sp[bk] = d;
    else              m_shared[a] = d;
  endtask

  // Effect of one clock edge without reset. Lower-priority sources are
  // applied first so that higher-priority ones overwrite them.
  task automatic m_apply(stim_t s);
    int bk = int'(m_cpsr % 4);
    if (s.pc_we) m_pc = s.pc_in;
    if (s.rb_we) m_store(int'(s.wrb), s.rb_in, bk);
    if (s.rd_we) m_store(int'(s.wrd), s.rd_in, bk);
    if (s.cpsr_we) m_cpsr = s.cpsr_in;
    if (s.rb_we) m_reserved[s.wrb] = 0;
    if (s.rd_we) m_reserved[s.wrd] = 0;
    if (s.issue_we) m_reserved[s.issue_rd] = 1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 13; i++) m_shared[i] = '0;
    for (int b = 0; b < 4; b++) begin
      m_sp[b] = '0;
      m_lr[b] = '0;
    end
    m_pc = '0;
    m_cpsr = '0;
    for (int i = 0; i < 16; i++) m_reserved[i] = 0;
  endtask

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(stim_t s);
    bus.read_rn  = s.rn;   bus.read_rm  = s.rm;   bus.read_rs = s.rs;
    bus.rd_we    = s.rd_we; bus.write_rd = s.wrd; bus.rd_in   = s.rd_in;
    bus.rb_we    = s.rb_we; bus.write_rb = s.wrb; bus.rb_in   = s.rb_in;
    bus.issue_we = s.issue_we; bus.issue_rd = s.issue_rd;
    bus.pc_we    = s.pc_we;   bus.pc_in    = s.pc_in;
    bus.cpsr_we  = s.cpsr_we; bus.cpsr_in  = s.cpsr_in;
  endtask

  task automatic step(input string tag, input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(s);
    e.tag  = tag;
    e.rn   = m_read(s, s.rn);
    e.rm   = m_read(s, s.rm);
    e.rs   = m_read(s, s.rs);
    e.rn_b = m_reserved[s.rn];
    e.rm_b = m_reserved[s.rm];
    e.rs_b = m_reserved[s.rs];
    e.pc   = m_pc;
    e.cpsr = m_cpsr;
    exp_q.push_back(e);
    m_apply(s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(idle());
    m_reset();
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " rn_out"},   bus.rn_out,   e.rn);
        check({e.tag, " rm_out"},   bus.rm_out,   e.rm);
        check({e.tag, " rs_out"},   bus.rs_out,   e.rs);
        check({e.tag, " rn_busy"},  32'(bus.rn_busy), 32'(e.rn_b));
        check({e.tag, " rm_busy"},  32'(bus.rm_busy), 32'(e.rm_b));
        check({e.tag, " rs_busy"},  32'(bus.rs_busy), 32'(e.rs_b));
        check({e.tag, " pc_out"},   bus.pc_out,   e.pc);
        check({e.tag, " cpsr_out"}, bus.cpsr_out, e.cpsr);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    drive(idle());
    m_reset();
    do_reset();

    // Reset state: zeros, r15 reads the offset only.
    s = idle(); s.rn = 4'd0; s.rm = 4'd15; s.rs = 4'd5;
    step("reset", s);

    // 42 into every register through port A, read back via bypass.
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.rd_we = 1'b1; s.wrd = 4'(i); s.rd_in = 32'd42;
      s.rn = 4'(i); s.rm = 4'd15; s.rs = 4'(i);
      step("fill42", s);
    end
    s = idle(); s.rn = 4'd15; s.rm = 4'd0; s.rs = 4'd14;
    step("fill42_after", s);

    // Port collisions.
    s = idle(); s.rd_we = 1; s.wrd = 3; s.rd_in = 5; s.rb_we = 1; s.wrb = 3; s.rb_in = 9;
    s.rn = 3;
    step("collide", s);
    s = idle(); s.rd_we = 1; s.wrd = 5; s.rd_in = 7; s.rb_we = 1; s.wrb = 4; s.rb_in = 9;
    s.rn = 3; s.rm = 4; s.rs = 5;
    step("dual_write", s);
    s = idle(); s.rn = 3; s.rm = 4; s.rs = 5;
    step("dual_after", s);

    // Banking of r13.
    do_reset();
    s = idle(); s.cpsr_we = 1; s.cpsr_in = 1; s.rn = 13;
    step("bank_set1", s);
    s = idle(); s.rd_we = 1; s.wrd = 13; s.rd_in = 32'h100; s.rn = 13;
    step("bank_w13", s);
    s = idle(); s.cpsr_we = 1; s.cpsr_in = 0; s.rn = 13;
    step("bank_set0", s);
    s = idle(); s.rn = 13;
    step("bank_rd0", s);
    s = idle(); s.cpsr_we = 1; s.cpsr_in = 1; s.rn = 13;
    step("bank_set1b", s);
    s = idle(); s.rn = 13;
    step("bank_rd1", s);

    // Scoreboard.
    s = idle(); s.issue_we = 1; s.issue_rd = 6; s.rn = 6;
    step("sb_issue", s);
    s = idle(); s.rn = 6;
    step("sb_busy", s);
    s = idle(); s.rb_we = 1; s.wrb = 6; s.rb_in = 32'h66; s.rn = 6;
    step("sb_wb", s);
    s = idle(); s.rn = 6;
    step("sb_clear", s);
    s = idle(); s.issue_we = 1; s.issue_rd = 6; s.rd_we = 1; s.wrd = 6; s.rd_in = 1; s.rn = 6;
    step("sb_both", s);
    s = idle(); s.rn = 6;
    step("sb_rearmed", s);

    // PC wrap and PC write priority.
    s = idle(); s.rd_we = 1; s.wrd = 2; s.rd_in = 32'hFFFF_FFFF;
    s.pc_we = 1; s.pc_in = 32'hFFFF_FFFC; s.rn = 2;
    step("pc_wrap_w", s);
    s = idle(); s.rn = 15; s.rm = 2;
    step("pc_wrap_r", s);
    s = idle(); s.rd_we = 1; s.wrd = 15; s.rd_in = 32'h20; s.pc_we = 1; s.pc_in = 32'h40;
    s.rn = 15;
    step("pc_prio_w", s);
    s = idle(); s.rn = 15;
    step("pc_prio_r", s);

    // Reset discards reservations and data.
    s = idle(); s.issue_we = 1; s.issue_rd = 1;
    step("rst_issue", s);
    s = idle(); s.rd_we = 1; s.wrd = 7; s.rd_in = 3; s.rn = 1;
    step("rst_w7", s);
    do_reset();
    s = idle(); s.rn = 1; s.rm = 7; s.rs = 6;
    step("rst_after", s);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) begin
        do_reset();
      end else begin
        s.rn       = 4'($urandom_range(15));
        s.rm       = 4'($urandom_range(15));
        s.rs       = 4'($urandom_range(15));
        s.rd_we    = ($urandom_range(1) == 0);
        s.wrd      = 4'($urandom_range(15));
        s.rd_in    = $urandom;
        s.rb_we    = ($urandom_range(1) == 0);
        s.wrb      = ($urandom_range(3) == 0) ? s.wrd : 4'($urandom_range(15));
        s.rb_in    = $urandom;
        s.issue_we = ($urandom_range(2) == 0);
        s.issue_rd = 4'($urandom_range(15));
        s.pc_we    = ($urandom_range(7) == 0);
        s.pc_in    = $urandom;
        s.cpsr_we  = ($urandom_range(9) == 0);
        s.cpsr_in  = $urandom;
        step("rand", s);
      end
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
